word_unpack_7: RTL
==================

WORD_UNPACK_7 -- requirements
Module: word_unpack_7

Interface
REQ-001 Parameter DEPTH, default 2, sets the number of buffered 128-bit words; legal values are powers of two, 2 to 16.
REQ-002 clk_i  input  1  the single clock; all state is updated on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 in_valid_i  input  1  data_in holds a word offered for transfer.
REQ-005 in_ready_o  output  1  the block can accept a word this cycle.
REQ-006 data_in  input  128  packed word: bits [127:120] are field 1, bits [119:0] are field 0.
REQ-007 out0_valid_o  output  1  data_out0 holds field 0 of the head word.
REQ-008 out0_ready_i  input  1  the consumer of field 0 accepts it this cycle.
REQ-009 data_out0  output  120  field 0 of the head word.
REQ-010 out1_valid_o  output  1  data_out1 holds field 1 of the head word.
REQ-011 out1_ready_i  input  1  the consumer of field 1 accepts it this cycle.
REQ-012 data_out1  output  8  field 1 of the head word.
REQ-013 word_cnt_o  output  32  count of fully retired words; the port is present only when WORD_UNPACK7_STATS_EN is defined.

Function
REQ-014 An input transfer occurs when in_valid_i and in_ready_o are both high; the word is written at the tail of a DEPTH-entry circular buffer.
REQ-015 in_ready_o SHALL be high exactly when occupancy < DEPTH; it depends on registered state only, so when the buffer is full a same-cycle pop does not enable a push.
REQ-016 A word accepted at edge N is visible on data_out0/data_out1 with its valid flags high from edge N onward (one-cycle latency, no combinational input-to-output path).
REQ-017 Each head word carries two taken flags, t0 and t1, cleared whenever a new head word is presented.
REQ-018 out0_valid_o = (occupancy != 0) and not t0; out1_valid_o = (occupancy != 0) and not t1.
REQ-019 A field-0 transfer (out0_valid_o and out0_ready_i) sets t0; a field-1 transfer sets t1; the two channels are independent, and either one may complete first.
REQ-020 The head word retires, advancing the read pointer and decrementing occupancy, in the cycle where each field is either already taken or transferring that cycle; t0 and t1 then clear.
REQ-021 If push and retire happen in the same cycle, occupancy is unchanged.
REQ-022 Read and write pointers wrap modulo DEPTH; occupancy ranges from 0 to DEPTH inclusive.
REQ-023 When empty, data_out0 and data_out1 hold the last head value, or zero after reset; consumers must not sample them while the valid flags are low.
REQ-024 out*_ready_i asserted while the matching valid is low has no effect.

Reset
REQ-025 Assertion of rst_i SHALL immediately clear the pointers, occupancy, t0, t1 and word_cnt_o; in_ready_o goes high and both valid flags go low.
REQ-026 Reset asserted mid-operation discards all buffered words, including a partially taken head word; buffer storage need not be cleared.
REQ-027 After reset, data_out0 and data_out1 read as 0 until the first word is accepted.

Configuration
REQ-028 Macro WORD_UNPACK7_STATS_EN: when defined, word_cnt_o increments by 1 on every retire and wraps from 0xFFFFFFFF to 0.
REQ-029 When WORD_UNPACK7_STATS_EN is undefined, the word_cnt_o port and its counter do not exist; all other behaviour is identical.

Structure
REQ-030 A shared package word_pack7_pkg holds the field constants (F0_W = 120, F1_W = 8, WORD_W = 128, F1_LSB = 120) and a packed struct typedef {f1, f0} used by both the packer and this unpacker.
REQ-031 One sub-module, word_unpack7_buf, implements the circular storage, pointers and occupancy; the top level holds the taken flags, valid logic and statistics counter.

Verification
REQ-032 Reset, then push 0xAB followed by 120'h1 with both readies high -> next cycle data_out1 = 0xAB, data_out0 = 1, both valids high; the word retires that cycle and word_cnt_o = 1.
REQ-033 With DEPTH = 2, push 3 words while both readies are low -> in_ready_o goes low after word 2 and word 3 is held off; both valids stay high on word 1.
REQ-034 Head word present; assert out1_ready_i only -> out1_valid_o drops the next cycle, out0_valid_o stays high, and there is no retire; then assert out0_ready_i -> the word retires and the next word appears with both valids high.
REQ-035 Stream 20 words with random independent readies and continuous push -> both outputs deliver all 20 words in order without loss or duplication, pointer wrap occurs, and word_cnt_o = 20.
REQ-036 Buffer full, push and retire in the same cycle -> the push is refused because in_ready_o was low; occupancy becomes DEPTH - 1, and next cycle in_ready_o = 1.
REQ-037 Assert rst_i asynchronously between clock edges with 2 words buffered and t0 set -> the valids drop before the next edge, in_ready_o = 1 and word_cnt_o = 0.

Source files
------------

// File: rtl/word_pack7_pkg.sv
// Shared field layout for the 7-series word packer/unpacker pair.
package word_pack7_pkg;

    localparam int F0_W   = 120;
    localparam int F1_W   = 8;
    localparam int WORD_W = 128;
    localparam int F1_LSB = 120;

    typedef struct packed {
        logic [F1_W-1:0] f1;
        logic [F0_W-1:0] f0;
    } word_t;

endpackage

// File: rtl/word_unpack7_buf.sv
// Circular word store with pointers, occupancy and a registered head-word copy.
module word_unpack7_buf
    import word_pack7_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  word_t                      wr_data_i,
    output word_t                      head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    word_t              mem_q [DEPTH];
    word_t              head_q;
    word_t              head_d;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [PTR_W-1:0]   rd_nxt_s;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    assign rd_nxt_s = rd_ptr_q + PTR_W'(1);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = rd_nxt_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Head copy tracks the entry that will sit at rd_ptr after this edge;
    // a push into an empty (or emptying) buffer bypasses storage.
    always_comb begin
        head_d = head_q;
        if (pop_i) begin
            if (count_q > CNT_W'(1)) begin
                head_d = mem_q[rd_nxt_s];
            end else if (push_i) begin
                head_d = wr_data_i;
            end else begin
                head_d = head_q;
            end
        end else if (push_i && (count_q == CNT_W'(0))) begin
            head_d = wr_data_i;
        end else begin
            head_d = head_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are don't-care after reset
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/word_unpack_7.sv
// Splits buffered 128-bit words into independent field-0/field-1 streams.
// Optional retire counter enabled by defining WORD_UNPACK7_STATS_EN.
module word_unpack_7
    import word_pack7_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [WORD_W-1:0]   data_in,
    output logic                out0_valid_o,
    input  logic                out0_ready_i,
    output logic [F0_W-1:0]     data_out0,
    output logic                out1_valid_o,
    input  logic                out1_ready_i,
    output logic [F1_W-1:0]     data_out1
`ifdef WORD_UNPACK7_STATS_EN
    ,
    output logic [31:0]         word_cnt_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    word_t              head_s;
    word_t              wr_word_s;
    logic [CNT_W-1:0]   count_s;
    logic               not_empty_s;
    logic               push_s;
    logic               xfer0_s;
    logic               xfer1_s;
    logic               retire_s;
    logic               t0_q;
    logic               t0_d;
    logic               t1_q;
    logic               t1_d;

    assign wr_word_s   = word_t'(data_in);
    assign not_empty_s = (count_s != CNT_W'(0));
    assign in_ready_o  = (count_s < CNT_W'(DEPTH));
    assign push_s      = in_valid_i && in_ready_o;

    assign out0_valid_o = not_empty_s && !t0_q;
    assign out1_valid_o = not_empty_s && !t1_q;
    assign xfer0_s      = out0_valid_o && out0_ready_i;
    assign xfer1_s      = out1_valid_o && out1_ready_i;
    assign retire_s     = (t0_q || xfer0_s) && (t1_q || xfer1_s);

    assign data_out0 = head_s[F0_W-1:0];
    assign data_out1 = head_s[F1_LSB +: F1_W];

    word_unpack7_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push_s),
        .pop_i     (retire_s),
        .wr_data_i (wr_word_s),
        .head_o    (head_s),
        .count_o   (count_s)
    );

    // Taken flags: set on a field transfer, cleared when the head retires
    always_comb begin
        t0_d = t0_q;
        t1_d = t1_q;
        if (retire_s) begin
            t0_d = 1'b0;
            t1_d = 1'b0;
        end else begin
            t0_d = t0_q || xfer0_s;
            t1_d = t1_q || xfer1_s;
        end
    end

    // Taken flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            t0_q <= 1'b0;
            t1_q <= 1'b0;
        end else begin
            t0_q <= t0_d;
            t1_q <= t1_d;
        end
    end

`ifdef WORD_UNPACK7_STATS_EN
    logic [31:0] word_cnt_q;
    logic [31:0] word_cnt_d;

    // Retire counter, wraps naturally at 2^32
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (retire_s) begin
            word_cnt_d = word_cnt_q + 32'd1;
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // Retire counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_cnt_q <= 32'd0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt_o = word_cnt_q;
`endif

endmodule
